// File: rtl/de0nano_user_io.sv
// DE0-Nano user I/O: key sync/debounce with press/release pulses and a
// four-mode LED display (status+heartbeat, press count, scanner, external).
module de0nano_user_io #(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_LEDS        = 8,
    parameter int HB_WIDTH        = 26,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_DIV        = 2500000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_LEDS-1:0] ext_pattern,
    output logic [NUM_LEDS-1:0] LED,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_up,
    output logic [1:0]          mode
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SDW-1:0] SD_MAX = SDW'(SCAN_DIV - 1);
    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] POS_TOP = PW'(NUM_LEDS - 1);
    localparam int NLK = (NUM_KEYS < NUM_LEDS) ? NUM_KEYS : NUM_LEDS;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] sync_k;

    // Synchronisers come out of reset as "released" so held keys re-qualify
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign sync_k = ~sync2_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
        logic [DBW-1:0] cnt_q;
        logic           lvl_q;
        logic           dn_q;
        logic           up_q;

        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
                dn_q  <= 1'b0;
                up_q  <= 1'b0;
            end else begin
                dn_q <= 1'b0;
                up_q <= 1'b0;
                if (sync_k[k] == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_MAX) begin
                    cnt_q <= '0;
                    lvl_q <= sync_k[k];
                    dn_q  <= sync_k[k];
                    up_q  <= ~sync_k[k];
                end else begin
                    cnt_q <= cnt_q + DBW'(1);
                end
            end
        end

        assign key_level[k] = lvl_q;
        assign key_down[k]  = dn_q;
        assign key_up[k]    = up_q;
    end

    logic [1:0]          mode_q;
    logic [NUM_LEDS-1:0] press_q;
    logic [HB_WIDTH-1:0] hb_q;
    logic [SDW-1:0]      pre_q;
    logic [PW-1:0]       pos_q;
    logic                dir_down_q;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] led_d;
    logic [NUM_LEDS-1:0] led_m0;
    logic                scan_tick;

    assign scan_tick = (pre_q == SD_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            mode_q     <= 2'd0;
            press_q    <= '0;
            hb_q       <= '0;
            pre_q      <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            led_q      <= '0;
        end else begin
            hb_q  <= hb_q + HB_WIDTH'(1);
            pre_q <= scan_tick ? '0 : pre_q + SDW'(1);
            if (key_down[NUM_KEYS-1]) mode_q <= mode_q + 2'd1;
            if (key_down[0]) press_q <= press_q + NUM_LEDS'(1);
            // Endpoints bounce straight back so no position is shown twice
            if (scan_tick) begin
                if (!dir_down_q) begin
                    if (pos_q == POS_TOP) begin
                        dir_down_q <= 1'b1;
                        pos_q      <= pos_q - PW'(1);
                    end else begin
                        pos_q <= pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        dir_down_q <= 1'b0;
                        pos_q      <= PW'(1);
                    end else begin
                        pos_q <= pos_q - PW'(1);
                    end
                end
            end
            led_q <= led_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_m0
        if (i < NLK) begin : g_key
            assign led_m0[i] = key_level[i];
        end else begin : g_hb
            assign led_m0[i] = hb_q[HB_WIDTH-2-(i-NUM_KEYS)];
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode_q)
            2'd0: led_d = led_m0;
            2'd1: led_d = press_q;
            2'd2: led_d = NUM_LEDS'(1) << pos_q;
            2'd3: led_d = ext_pattern;
        endcase
    end

    assign LED  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_de0nano_user_io.sv
// Randomised and directed bench for de0nano_user_io against a
// history-based behavioural model of keys, modes, counter and scanner.
module tb_de0nano_user_io;

    localparam int NK  = 2;
    localparam int NL  = 8;
    localparam int HBW = 12;
    localparam int DB  = 4;
    localparam int SD  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '1;
    logic [NL-1:0] ext = '0;
    logic [NL-1:0] led;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_down;
    logic [NK-1:0] key_up;
    logic [1:0]    mode;

    de0nano_user_io #(
        .NUM_KEYS(NK), .NUM_LEDS(NL), .HB_WIDTH(HBW),
        .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .ext_pattern(ext),
        .LED(led), .key_level(key_level), .key_down(key_down),
        .key_up(key_up), .mode(mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int dn_cnt[NK];
    int up_cnt[NK];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw pin samples, synced-sample history, and edges since reset
    bit [NK-1:0] m_ph[$];
    bit [NK-1:0] m_sh[$];
    bit [NK-1:0] m_lvl, m_dn, m_up;
    bit [1:0]    m_mode;
    bit [NL-1:0] m_cnt, m_led;
    int          m_e;

    function automatic bit [NL-1:0] scan_led(input int t);
        int p;
        int pos;
        p = (t / SD) % (2 * (NL - 1));
        pos = (p < NL) ? p : 2 * (NL - 1) - p;
        return NL'(1) << pos;
    endfunction

    function automatic bit [NL-1:0] mode0_led();
        bit [NL-1:0]  l;
        bit [HBW-1:0] hb;
        hb = HBW'(m_e % (1 << HBW));
        for (int k = 0; k < NL; k++)
            l[k] = (k < NK) ? m_lvl[k] : hb[HBW-2-(k-NK)];
        return l;
    endfunction

    task automatic model_reset();
        m_ph.delete();
        m_ph.push_back('1);
        m_ph.push_back('1);
        m_sh.delete();
        m_lvl = '0; m_dn = '0; m_up = '0;
        m_mode = '0; m_cnt = '0; m_led = '0; m_e = 0;
    endtask

    task automatic model_edge(input bit [NK-1:0] kin, input bit [NL-1:0] ex);
        bit [NK-1:0] s, ndn, nup;
        bit          all;
        case (m_mode)
            2'd0: m_led = mode0_led();
            2'd1: m_led = m_cnt;
            2'd2: m_led = scan_led(m_e);
            default: m_led = ex;
        endcase
        if (m_dn[NK-1]) m_mode = m_mode + 2'd1;
        if (m_dn[0]) m_cnt = m_cnt + 1'b1;
        s = ~m_ph.pop_front();
        m_ph.push_back(kin);
        m_sh.push_back(s);
        if (m_sh.size() > DB) void'(m_sh.pop_front());
        ndn = '0;
        nup = '0;
        if (m_sh.size() == DB) begin
            for (int k = 0; k < NK; k++) begin
                all = 1'b1;
                foreach (m_sh[j]) if (m_sh[j][k] == m_lvl[k]) all = 1'b0;
                if (all) begin
                    m_lvl[k] = ~m_lvl[k];
                    if (m_lvl[k]) ndn[k] = 1'b1;
                    else nup[k] = 1'b1;
                end
            end
        end
        m_dn = ndn;
        m_up = nup;
        m_e++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(key, ext);
        #1;
        check("led", led, m_led);
        check("key_level", key_level, m_lvl);
        check("key_down", key_down, m_dn);
        check("key_up", key_up, m_up);
        check("mode", mode, m_mode);
        for (int k = 0; k < NK; k++) begin
            if (key_down[k]) dn_cnt[k]++;
            if (key_up[k]) up_cnt[k]++;
        end
    endtask

    task automatic press(input int b);
        key[b] = 1'b0;
        repeat (8) tick();
        key[b] = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        key = '1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int n, at, d0, u0, lc;
        bit found, s80, s01;
        logic [NL-1:0] prev, nup, ndn;
        for (int k = 0; k < NK; k++) begin
            dn_cnt[k] = 0;
            up_cnt[k] = 0;
        end
        model_reset();

        // Keys held pressed through reset must re-qualify afterwards
        rst_n = 1'b0;
        key = 2'b00;
        repeat (3) tick();
        check("t1_rst_led", led, 0);
        check("t1_rst_mode", mode, 0);
        check("t1_rst_level", key_level, 0);
        rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (key_level == 2'b11) begin
                found = 1'b1;
                n = i;
                check("t1_down", key_down, 2'b11);
            end
        end
        check("t1_latency", n, 6);
        tick();
        check("t1_pulse_once", key_down, 0);

        key = 2'b11;
        repeat (12) tick();
        d0 = dn_cnt[0];
        key[0] = 1'b0;
        repeat (2) tick();
        key[0] = 1'b1;
        tick();
        key[0] = 1'b0;
        at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (key_down[0]) at = i;
        end
        check("t2_pulses", dn_cnt[0] - d0, 1);
        check("t2_latency", at, 6);
        u0 = up_cnt[0];
        key[0] = 1'b1;
        repeat (3) tick();
        key[0] = 1'b0;
        repeat (10) tick();
        check("t2_glitch", up_cnt[0] - u0, 0);
        key[0] = 1'b1;
        repeat (10) tick();
        check("t2_release", up_cnt[0] - u0, 1);

        ext = 8'hA5;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(1);
            check("t3_mode", mode, (i + 1) % 4);
            if (i == 2) check("t3_ext", led, 8'hA5);
        end

        press(1);
        check("t4_mode", mode, 1);
        for (int i = 0; i < 256; i++) begin
            press(0);
            check("t4_cnt", led, (i + 1) & 8'hFF);
        end

        press(1);
        check("t5_mode", mode, 2);
        prev = led;
        lc = -1;
        s80 = 1'b0;
        s01 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (led != prev) begin
                nup = prev << 1;
                ndn = prev >> 1;
                check("t5_adjacent", (led == nup) || (led == ndn), 1);
                if (lc >= 0) check("t5_step", i - lc, 2);
                lc = i;
                prev = led;
            end
            if (led == 8'h80) s80 = 1'b1;
            if (led == 8'h01 && s80) s01 = 1'b1;
        end
        check("t5_top_seen", s80, 1);
        check("t5_return_seen", s01, 1);

        press(1);
        press(1);
        check("t6_mode0", mode, 0);
        key = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (key_down != 0) begin
                found = 1'b1;
                check("t6_both", key_down, 2'b11);
            end
        end
        check("t6_found", found, 1);
        repeat (2) tick();
        check("t6_mode", mode, 1);
        check("t6_cnt", led, 1);
        key = 2'b11;
        repeat (10) tick();
        d0 = dn_cnt[0];
        u0 = up_cnt[0];
        key[0] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        key = 2'b11;
        rst_n = 1'b1;
        repeat (15) tick();
        check("t6_rst_down", dn_cnt[0] - d0, 0);
        check("t6_rst_up", up_cnt[0] - u0, 0);

        for (int seg = 0; seg < 500; seg++) begin
            key = NK'($urandom_range(0, 3));
            ext = NL'($urandom);
            rst_n = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 9)) tick();
        end
        rst_n = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
